vga_scene_sequencer: RTL and testbench
======================================

Name: vga_scene_sequencer

Overview:
Frame-synchronous controller that selects which scene the VGA drawing datapath renders and drives its animation frame count. It takes the raw centre push-button, synchronises and debounces it, and turns each press into a scene-advance request. Requests, plus optional timed auto-advance, are committed only at frame boundaries so the drawing datapath never changes scene mid-frame. It sits between the board-level button pins and the drawing block's scene/animation inputs.

Parameters:
NUM_SCENES, 4, number of scenes; scene_id wraps modulo this value (must be ≥2).
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles required to accept a button level change (10 ms at 100 MHz).
AUTO_FRAMES, 120, frames per scene in auto mode (must be ≥1).
ANIM_W, 8, width of anim_frame.

Ports:
clk  in  1  system clock, 100 MHz; single clock domain.
rst  in  1  reset; synchronous, active-high.
btn_raw  in  1  asynchronous raw push-button level, active-high.
auto_en  in  1  1 = auto-advance every AUTO_FRAMES frames; sampled on frame_start only.
frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blanking.
scene_id  out  $clog2(NUM_SCENES)  current scene index.
anim_frame  out  ANIM_W  frames elapsed since last scene commit.
scene_change  out  1  one-cycle pulse in the cycle after scene_id updates.
btn_press  out  1  one-cycle pulse per debounced rising edge (debug/LED).

Behaviour:
- Reset: all outputs 0, synchroniser FFs 0, debounced level 0, debounce counter 0, pending 0, state S_RUN. Reset asserted mid-operation drops any pending request and returns to these values at the next edge.
- Synchroniser: 2-FF on btn_raw. Debounce latency is 2 + DEBOUNCE_CYCLES cycles from the raw edge.
- Debounce: counter clears whenever the synchronised level equals the debounced level. When they differ, the counter increments. When it reaches DEBOUNCE_CYCLES-1 while they still differ, the debounced level flips and the counter clears. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- btn_press: registered. Asserts for 1 cycle on the debounced 0→1 transition. No pulse on release.
- pending flag: set by btn_press in any state. Cleared on commit. Multiple presses before a commit collapse into one advance.
- FSM:
  - S_RUN: on frame_start, anim_frame increments (wraps at 2^ANIM_W-1 → 0). Commit if (pending) or (auto_en and anim_frame == AUTO_FRAMES-1).
  - Commit (at that same edge): scene_id ← (scene_id+1) mod NUM_SCENES, anim_frame ← 0, pending ← 0, state ← S_HOLD. scene_change is 1 in the following cycle.
  - S_HOLD: guarantees every scene is shown for at least one full frame. The next frame_start increments anim_frame and moves to S_RUN without committing, even if pending. Presses during S_HOLD set pending and are honoured at the frame_start after that.
- Simultaneous btn_press and frame_start in S_RUN: the press is not seen by that frame_start (pending is registered). It commits at the next frame_start.
- Auto and pending at the same frame_start produce a single advance, not two.
- frame_start asserted for more than 1 cycle is treated as consecutive frames; the caller must guarantee a single-cycle pulse.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Package vga_ctrl_pkg holds:
  - seq_state_t enum {S_RUN, S_HOLD};
  - SCENE_W localparam function ($clog2 with a 1-bit minimum);
  - shared VGA timing constants reused by the drawing blocks.
- One sub-module, btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, raw, level, rise_pulse). It contains the synchroniser, counter and edge detector, and is reusable for other board buttons.

Test Plan (sim overrides: DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_SCENES=4; frame_start every 20 cycles):
- Reset: hold rst 3 cycles with btn_raw=1 and frame_start pulsing → scene_id=0, anim_frame=0, no scene_change or btn_press pulses; after release, btn_press occurs exactly 6 cycles later.
- Glitch reject: btn_raw high 3 cycles, then low → no btn_press, scene_id stays 0. Clean press held 10 cycles → one btn_press; next frame_start gives scene_id=1, anim_frame=0, and scene_change for 1 cycle.
- Collapse/wrap: 3 debounced presses between two frame_starts → single advance. Repeating 4 separate advances from scene 3 wraps to 0.
- Hold-off: press lands in S_HOLD right after a commit → no commit at the next frame_start (anim_frame=1); commit happens at the following one.
- Auto: auto_en=1, no presses → scene_id advances on every 3rd frame_start (0→1→2→3→0). A press pending at an auto-commit frame yields one increment only.
- Reset mid-request: press debounced (pending=1), rst asserted 1 cycle before frame_start → scene_id=0, pending dropped, no scene_change at later frame_starts.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the VGA control/drawing blocks.
// Holds the scene sequencer state type, the scene index width helper and 640x480 timing.
package vga_ctrl_pkg;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } seq_state_t;

    // Width of a scene index; never narrower than one bit.
    function automatic int scene_w(input int num_scenes);
        return (num_scenes <= 2) ? 1 : $clog2(num_scenes);
    endfunction

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_scene_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and registered rising-edge pulse.
// Reusable for any board button; latency from a raw edge is 2 + DEBOUNCE_CYCLES cycles.
module btn_debounce
    import vga_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            rise_reg <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability count.
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync_reg[1];
                rise_reg  <= sync_reg[1];
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level      = level_reg;
    assign rise_pulse = rise_reg;

endmodule

// File: rtl/vga_scene_sequencer.sv
// Frame-synchronous scene selector: button presses and timed auto-advance are committed
// only on frame_start, and every scene is held for at least one full frame after a commit.
module vga_scene_sequencer
    import vga_ctrl_pkg::*;
#(
    parameter int NUM_SCENES      = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_FRAMES     = 120,
    parameter int ANIM_W          = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             btn_raw,
    input  logic                             auto_en,
    input  logic                             frame_start,
    output logic [scene_w(NUM_SCENES)-1:0]   scene_id,
    output logic [ANIM_W-1:0]                anim_frame,
    output logic                             scene_change,
    output logic                             btn_press
);

    localparam int SCENE_W = scene_w(NUM_SCENES);
    localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);
    localparam logic [ANIM_W-1:0]  AUTO_LAST  = ANIM_W'(AUTO_FRAMES - 1);
    localparam logic [0:0]         ST_RUN     = S_RUN;
    localparam logic [0:0]         ST_HOLD    = S_HOLD;

    logic               press;
    logic               unused_btn_level;
    logic [0:0]         state_reg;
    logic               pending_reg;
    logic [SCENE_W-1:0] scene_reg;
    logic [ANIM_W-1:0]  anim_reg;
    logic               change_reg;
    logic               commit;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk        (clk),
        .rst        (rst),
        .raw        (btn_raw),
        .level      (unused_btn_level),
        .rise_pulse (press)
    );

    // Auto and pending share one condition, so both at once still advance only once.
    always_comb begin
        commit = 1'b0;
        if (frame_start && (state_reg == ST_RUN)) begin
            commit = pending_reg || (auto_en && (anim_reg == AUTO_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            pending_reg <= 1'b0;
            scene_reg   <= '0;
            anim_reg    <= '0;
            change_reg  <= 1'b0;
        end else begin
            change_reg <= commit;
            // A press landing on a commit edge survives and advances at the next frame.
            if (press) begin
                pending_reg <= 1'b1;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end
            if (frame_start) begin
                if (commit) begin
                    scene_reg <= (scene_reg == SCENE_LAST) ? '0 : scene_reg + 1'b1;
                    anim_reg  <= '0;
                    state_reg <= ST_HOLD;
                end else begin
                    anim_reg  <= anim_reg + 1'b1;
                    state_reg <= ST_RUN;
                end
            end
        end
    end

    assign scene_id     = scene_reg;
    assign anim_frame   = anim_reg;
    assign scene_change = change_reg;
    assign btn_press    = press;

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Self-checking bench for vga_scene_sequencer: directed frame table, hand-written corner
// sequences and randomized stimulus, all compared every cycle against a behavioural model.
module tb_vga_scene_sequencer;

    localparam int D  = 4;
    localparam int AF = 3;
    localparam int NS = 4;
    localparam int AW = 8;
    localparam int FP = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       auto_en;
    logic       frame_start;
    logic [1:0] scene_id;
    logic [7:0] anim_frame;
    logic       scene_change;
    logic       btn_press;

    vga_scene_sequencer #(
        .NUM_SCENES      (NS),
        .DEBOUNCE_CYCLES (D),
        .AUTO_FRAMES     (AF),
        .ANIM_W          (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .auto_en      (auto_en),
        .frame_start  (frame_start),
        .scene_id     (scene_id),
        .anim_frame   (anim_frame),
        .scene_change (scene_change),
        .btn_press    (btn_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: the button level is accepted once the last D synchronised
    // samples all disagree with it; frames follow the commit/hold rules in plain arithmetic.
    int m_scene = 0;
    int m_anim  = 0;
    bit m_hold = 0, m_pending = 0, m_change = 0, m_press = 0, m_level = 0;
    bit p1 = 0, p2 = 0;
    bit win[$];

    always @(posedge clk) begin : model
        bit synced, flip, rising, commit;
        if (rst) begin
            m_scene = 0; m_anim = 0; m_hold = 0; m_pending = 0;
            m_change = 0; m_press = 0; m_level = 0; p1 = 0; p2 = 0;
            win.delete();
        end else begin
            synced = p2;
            p2 = p1;
            p1 = btn_raw;
            win.push_back(synced);
            if (win.size() > D) void'(win.pop_front());
            flip = (win.size() == D);
            foreach (win[k]) if (win[k] == m_level) flip = 0;
            rising = flip && !m_level;
            commit = 0;
            if (frame_start) begin
                if (m_hold) begin
                    m_anim = (m_anim + 1) % (1 << AW);
                    m_hold = 0;
                end else if (m_pending || (auto_en && m_anim == AF - 1)) begin
                    commit  = 1;
                    m_scene = (m_scene + 1) % NS;
                    m_anim  = 0;
                    m_hold  = 1;
                end else begin
                    m_anim = (m_anim + 1) % (1 << AW);
                end
            end
            if (m_press) m_pending = 1;
            else if (commit) m_pending = 0;
            m_change = commit;
            if (flip) m_level = !m_level;
            m_press = rising;
        end
    end

    task automatic cycle(input logic r, input logic fs, input logic au, input logic rs);
        btn_raw = r; frame_start = fs; auto_en = au; rst = rs;
        @(negedge clk);
        check("model_scene_id", scene_id, m_scene);
        check("model_anim_frame", anim_frame, m_anim);
        check("model_scene_change", scene_change, m_change);
        check("model_btn_press", btn_press, m_press);
    endtask

    task automatic run_frame(input logic [FP-1:0] mask, input logic au);
        for (int i = 0; i < FP; i++) cycle(mask[i], i == FP - 1, au, 1'b0);
    endtask

    typedef struct {
        logic [FP-1:0] mask;
        logic          au;
        int            scene;
        int            anim;
        logic          chg;
    } vec_t;

    vec_t tbl[25];

    initial begin
        int lat;
        int run_left;
        logic r, au, fs, rs;

        // Each entry is one 20-cycle frame (bit i = btn_raw in cycle i, frame_start on the
        // last cycle) and the outputs expected just after that frame_start.
        tbl[0]  = '{20'h00007, 1'b0, 0, 1, 1'b0};  // 3-cycle glitch ignored
        tbl[1]  = '{20'h003FF, 1'b0, 1, 0, 1'b1};  // clean press commits
        tbl[2]  = '{20'h003FF, 1'b0, 1, 1, 1'b0};  // press during hold: deferred
        tbl[3]  = '{20'h00000, 1'b0, 2, 0, 1'b1};
        tbl[4]  = '{20'h00000, 1'b0, 2, 1, 1'b0};
        tbl[5]  = '{20'hF0000, 1'b0, 2, 2, 1'b0};  // press straddles the frame edge
        tbl[6]  = '{20'h0F0F0, 1'b0, 3, 0, 1'b1};  // three presses collapse into one
        tbl[7]  = '{20'h00000, 1'b0, 3, 1, 1'b0};
        tbl[8]  = '{20'h00000, 1'b0, 3, 2, 1'b0};
        tbl[9]  = '{20'hFF000, 1'b0, 0, 0, 1'b1};  // latest press that still commits; wrap
        tbl[10] = '{20'h00000, 1'b0, 0, 1, 1'b0};
        tbl[11] = '{20'hFE000, 1'b0, 0, 2, 1'b0};  // press pulse coincides with frame_start
        tbl[12] = '{20'h00000, 1'b0, 1, 0, 1'b1};
        tbl[13] = '{20'h00000, 1'b1, 1, 1, 1'b0};  // auto mode
        tbl[14] = '{20'h00000, 1'b1, 1, 2, 1'b0};
        tbl[15] = '{20'h00000, 1'b1, 2, 0, 1'b1};
        tbl[16] = '{20'h00000, 1'b1, 2, 1, 1'b0};
        tbl[17] = '{20'h00000, 1'b1, 2, 2, 1'b0};
        tbl[18] = '{20'h00000, 1'b1, 3, 0, 1'b1};
        tbl[19] = '{20'h00000, 1'b0, 3, 1, 1'b0};
        tbl[20] = '{20'h00000, 1'b0, 3, 2, 1'b0};
        tbl[21] = '{20'h003FF, 1'b1, 0, 0, 1'b1};  // auto and pending together: one step
        tbl[22] = '{20'h00000, 1'b1, 0, 1, 1'b0};
        tbl[23] = '{20'h00000, 1'b1, 0, 2, 1'b0};
        tbl[24] = '{20'h00000, 1'b1, 1, 0, 1'b1};

        // Reset with the button held and frame_start toggling.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, i[0], 1'b0, 1'b1);
            check("rst_scene_id", scene_id, 0);
            check("rst_anim_frame", anim_frame, 0);
            check("rst_scene_change", scene_change, 0);
            check("rst_btn_press", btn_press, 0);
        end
        lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (btn_press === 1'b1) lat = n;
        end
        check("press_latency_after_reset", lat, 6);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        for (int v = 0; v < 25; v++) begin
            run_frame(tbl[v].mask, tbl[v].au);
            $display("frame %0d: scene_id=%0d anim_frame=%0d scene_change=%0d", v,
                     scene_id, anim_frame, scene_change);
            check("tbl_scene_id", scene_id, tbl[v].scene);
            check("tbl_anim_frame", anim_frame, tbl[v].anim);
            check("tbl_scene_change", scene_change, tbl[v].chg);
        end

        // Pending press dropped by a reset one cycle before frame_start.
        for (int i = 0; i < FP; i++) cycle(i < 10, i == FP - 1, 1'b0, i == FP - 2);
        check("midrst_scene_id", scene_id, 0);
        check("midrst_anim_frame", anim_frame, 1);
        check("midrst_scene_change", scene_change, 0);
        run_frame('0, 1'b0);
        check("midrst_scene_id_2", scene_id, 0);
        check("midrst_anim_frame_2", anim_frame, 2);
        run_frame('0, 1'b0);
        check("midrst_scene_id_3", scene_id, 0);
        check("midrst_anim_frame_3", anim_frame, 3);

        // Randomized button runs, frame spacing, auto mode and occasional resets.
        run_left = 0;
        r = 1'b0;
        au = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                r = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            fs = ($urandom_range(0, 11) == 0);
            if (fs) au = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 399) == 0);
            cycle(r, fs, au, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
